// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared states, I/O offsets and reset constants
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } state_e;

    localparam logic [7:0] IO_OUT    = 8'h00;
    localparam logic [7:0] IO_TIMER  = 8'h01;
    localparam logic [7:0] IO_CMP    = 8'h02;
    localparam logic [7:0] IO_STATUS = 8'h03;

    localparam logic [15:0] CMP_RESET = 16'hFFFF;

    function automatic logic is_io(input logic [15:0] addr, input logic [15:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - CPU-side request/ready bus
interface mem_bus_responder_if;
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;

    modport master (output req, addr, we, wdata, input ready, rdata);
    modport slave  (input req, addr, we, wdata, output ready, rdata);
endinterface

// File: rtl/mem_bus_responder_io_timer.sv
// rtl/mem_bus_responder_io_timer.sv - free-running timer, compare, sticky match status
module mem_bus_responder_io_timer
    import mem_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_we_i,
    input  logic        cmp_we_i,
    input  logic        status_clr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] timer_o,
    output logic [15:0] cmp_o,
    output logic        irq_o
);

    logic [15:0] timer_q, timer_d;
    logic [15:0] cmp_q, cmp_d;
    logic        status_q, status_d;

    // Match uses the pre-increment value; a set wins over a same-cycle clear.
    always_comb begin
        timer_d  = timer_we_i ? wdata_i : timer_q + 16'd1;
        cmp_d    = cmp_we_i ? wdata_i : cmp_q;
        status_d = status_q;
        if (status_clr_i) begin
            status_d = 1'b0;
        end
        if (timer_q == cmp_q) begin
            status_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= 16'h0000;
            cmp_q    <= CMP_RESET;
            status_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    assign timer_o = timer_q;
    assign cmp_o   = cmp_q;
    assign irq_o   = status_q;

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - bus target: RAM forwarding with wait states plus I/O page
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter logic [15:0] IO_BASE     = 16'hFF00,
    parameter int          WAIT_STATES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_bus_responder_if.slave         bus,
    output logic                       ramEn,
    output logic                       ramWe,
    output logic [15:0]                ramAddr,
    output logic [15:0]                ramWdata,
    input  logic [15:0]                ramRdata,
    output logic [15:0]                outPort,
    output logic                       irq
);

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic [15:0] rdata_q;
    logic [15:0] out_q;
    logic        we_q;

    logic        accept, io_hit, io_wr;
    logic [7:0]  offset;
    logic [15:0] io_rdata;
    logic [15:0] timer, cmp;

    assign accept   = (state_q == ST_IDLE) && bus.req;
    assign io_hit   = is_io(bus.addr, IO_BASE);
    assign offset   = bus.addr[7:0];
    assign io_wr    = accept && io_hit && bus.we;

    // RAM strobe is combinational so the access starts in the accept cycle.
    assign ramEn    = accept && !io_hit;
    assign ramWe    = ramEn && bus.we;
    assign ramAddr  = bus.addr;
    assign ramWdata = bus.wdata;

    always_comb begin
        io_rdata = 16'h0000;
        case (offset)
            IO_OUT:    io_rdata = out_q;
            IO_TIMER:  io_rdata = timer;
            IO_CMP:    io_rdata = cmp;
            IO_STATUS: io_rdata = {15'h0000, irq};
            default:   io_rdata = 16'h0000;
        endcase
    end

    mem_bus_responder_io_timer u_io_timer (
        .clk          (clk),
        .rst          (rst),
        .timer_we_i   (io_wr && offset == IO_TIMER),
        .cmp_we_i     (io_wr && offset == IO_CMP),
        .status_clr_i (io_wr && offset == IO_STATUS && bus.wdata[0]),
        .wdata_i      (bus.wdata),
        .timer_o      (timer),
        .cmp_o        (cmp),
        .irq_o        (irq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            rdata_q <= 16'h0000;
            out_q   <= 16'h0000;
            we_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_q <= bus.we;
                        if (io_hit) begin
                            rdata_q <= bus.we ? 16'h0000 : io_rdata;
                            ready_q <= 1'b1;
                            state_q <= ST_RESP;
                            if (bus.we && offset == IO_OUT) begin
                                out_q <= bus.wdata;
                            end
                        end else begin
                            cnt_q   <= WS_CNT;
                            state_q <= ST_RAM_WAIT;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q <= we_q ? 16'h0000 : ramRdata;
                        ready_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign outPort   = out_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - vector table plus scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;

    localparam int WS = 2;
    localparam int LAT_IO = 1;
    localparam int LAT_RAM = 2 + WS;

    logic        clk;
    logic        rst;
    logic        ramEn, ramWe, irq;
    logic [15:0] ramAddr, ramWdata, ramRdata, outPort;

    mem_bus_responder_if bus();

    mem_bus_responder #(.IO_BASE(16'hFF00), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ramEn    (ramEn),
        .ramWe    (ramWe),
        .ramAddr  (ramAddr),
        .ramWdata (ramWdata),
        .ramRdata (ramRdata),
        .outPort  (outPort),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic prev_ready = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] ram_rd;
        logic [15:0] exp_rdata;
        logic [15:0] exp_out;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: ready with empty scoreboard, rdata %h", name, bus.rdata);
        end else begin
            e = exp_q.pop_front();
            chk(name, {16'h0, bus.rdata}, {16'h0, e});
        end
    endtask

    // ready must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (prev_ready) begin
            n_checks = n_checks + 1;
            if (bus.ready) begin
                n_fail = n_fail + 1;
                $display("FAIL ready_consecutive: got 1, expected 0");
            end
        end
        prev_ready <= bus.ready;
    end

    task automatic txn(input vec_t v, input int idx);
        int  n;
        bit  got;
        logic is_ram;
        is_ram = (v.addr < 16'hFF00);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.addr  = v.addr;
        bus.we    = v.we;
        bus.wdata = v.wdata;
        ramRdata  = v.ram_rd;
        exp_q.push_back(v.exp_rdata);
        #1;
        chk($sformatf("v%0d ramEn", idx), {31'h0, ramEn}, {31'h0, is_ram});
        if (is_ram) begin
            chk($sformatf("v%0d ramAddr", idx), {16'h0, ramAddr}, {16'h0, v.addr});
            chk($sformatf("v%0d ramWe", idx), {31'h0, ramWe}, {31'h0, v.we});
            if (v.we) chk($sformatf("v%0d ramWdata", idx), {16'h0, ramWdata}, {16'h0, v.wdata});
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1 && is_ram) chk($sformatf("v%0d ramEn_drop", idx), {31'h0, ramEn}, 32'h0);
            if (bus.ready) begin
                got = 1'b1;
                sb_pop($sformatf("v%0d rdata", idx));
                chk($sformatf("v%0d latency", idx), n, v.lat);
                chk($sformatf("v%0d outPort", idx), {16'h0, outPort}, {16'h0, v.exp_out});
            end
        end
        bus.req = 1'b0;
        if (!got) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL v%0d timeout: got no ready, expected ready", idx);
            exp_q.delete();
        end
    endtask

    function automatic bit exp_irq(input int k);
        return (k >= 7 && k <= 8) || (k >= 22 && k <= 28);
    endfunction

    function automatic bit exp_rdy(input int k);
        return (k == 1) || (k == 9) || (k == 11) || (k == 23) || (k == 27) || (k == 29);
    endfunction

    task automatic drive_wr(input logic [15:0] a, input logic [15:0] d);
        bus.req = 1'b1;
        bus.addr = a;
        bus.we = 1'b1;
        bus.wdata = d;
        exp_q.push_back(16'h0000);
    endtask

    initial begin
        vecs[0]  = '{16'hFF03, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, LAT_IO};
        vecs[1]  = '{16'h0100, 1'b1, 16'h00A5, 16'h0000, 16'h0000, 16'h0000, LAT_RAM};
        vecs[2]  = '{16'h0100, 1'b0, 16'h0000, 16'h00A5, 16'h00A5, 16'h0000, LAT_RAM};
        vecs[3]  = '{16'hFF00, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[4]  = '{16'hFF00, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, LAT_IO};
        vecs[5]  = '{16'hFF10, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[6]  = '{16'hFF10, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[7]  = '{16'hFF00, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, LAT_IO};
        vecs[8]  = '{16'hFEFF, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h1234, LAT_RAM};
        vecs[9]  = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[10] = '{16'hFF02, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[11] = '{16'hFF02, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h1234, LAT_IO};
        vecs[12] = '{16'hFF01, 1'b1, 16'h8000, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[13] = '{16'hFF01, 1'b0, 16'h0000, 16'h0000, 16'h8001, 16'h1234, LAT_IO};
        vecs[14] = '{16'hFF03, 1'b1, 16'h0001, 16'h0000, 16'h0000, 16'h1234, LAT_IO};
        vecs[15] = '{16'hFF03, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, LAT_IO};

        rst = 1'b1;
        bus.req = 1'b0;
        bus.addr = 16'h0000;
        bus.we = 1'b0;
        bus.wdata = 16'h0000;
        ramRdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", {31'h0, bus.ready}, 32'h0);
        chk("rst rdata", {16'h0, bus.rdata}, 32'h0);
        chk("rst ramEn", {31'h0, ramEn}, 32'h0);
        chk("rst outPort", {16'h0, outPort}, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) txn(vecs[i], i);

        // req held high across two I/O reads
        @(negedge clk);
        bus.req = 1'b1;
        bus.addr = 16'hFF00;
        bus.we = 1'b0;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk($sformatf("b2b ready n%0d", n), {31'h0, bus.ready}, {31'h0, (n == 1 || n == 3)});
            if (bus.ready) sb_pop($sformatf("b2b rdata n%0d", n));
            if (n == 4) bus.req = 1'b0;
        end
        chk("b2b sb_empty", exp_q.size(), 0);

        // timer match, W1C clear, and clear coinciding with a match
        @(negedge clk);
        drive_wr(16'hFF01, 16'h0000);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk($sformatf("irq_seq ready k%0d", k), {31'h0, bus.ready}, {31'h0, exp_rdy(k)});
            if (bus.ready) sb_pop($sformatf("irq_seq rdata k%0d", k));
            chk($sformatf("irq_seq irq k%0d", k), {31'h0, irq}, {31'h0, exp_irq(k)});
            case (k)
                1, 9, 11, 23, 27, 29: bus.req = 1'b0;
                8, 26, 28:            drive_wr(16'hFF03, 16'h0001);
                10:                   drive_wr(16'hFF02, 16'd20);
                22:                   drive_wr(16'hFF01, 16'd17);
                default: ;
            endcase
        end

        // reset while waiting on RAM drops the transaction
        @(negedge clk);
        bus.req = 1'b1;
        bus.addr = 16'h0200;
        bus.we = 1'b0;
        ramRdata = 16'hCAFE;
        @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk($sformatf("rst_wait ready n%0d", n), {31'h0, bus.ready}, 32'h0);
        end
        chk("rst_wait outPort", {16'h0, outPort}, 32'h0);
        chk("rst_wait irq", {31'h0, irq}, 32'h0);
        txn('{16'hFF00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, LAT_IO}, 100);
        txn('{16'hFF02, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, LAT_IO}, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU data/instruction bus: accepts single-word read/write requests from the CPU controller and returns data with a one-cycle `ready` pulse. Addresses below `IO_BASE` are forwarded to an external synchronous RAM with configurable wait states; addresses at or above `IO_BASE` hit an internal I/O page (output port, free-running timer, compare register, status/IRQ). It is the target end of the bus whose initiator is the CPU control unit.

## Interface
Parameters:
- `IO_BASE`, 16'hFF00, first address of I/O page (page is 256 words)
- `WAIT_STATES`, 2, extra RAM cycles after strobe before data capture (0..15)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, all logic on rising edge
- `rst` in 1 — synchronous active-high reset
- `req` in 1 — CPU request valid
- `addr` in 16 — word address
- `we` in 1 — 1 = write, 0 = read
- `wdata` in 16 — write data
- `ready` out 1 — one-cycle completion pulse
- `rdata` out 16 — read data, valid while `ready`=1
- `ramEn` out 1 — one-cycle RAM access strobe
- `ramWe` out 1 — RAM write enable (qualified by `ramEn`)
- `ramAddr` out 16 — RAM address
- `ramWdata` out 16 — RAM write data
- `ramRdata` in 16 — RAM read data, valid from cycle after `ramEn` until next `ramEn`
- `outPort` out 16 — I/O output port register
- `irq` out 1 — timer match interrupt, level = STATUS[0]

## Operation
- States: IDLE, RAM_WAIT, RESP.
- IDLE, `req`=1, `addr`<`IO_BASE`: `ramEn`=1, `ramWe`=`we`, `ramAddr`/`ramWdata` driven from inputs this cycle; load `cnt`=`WAIT_STATES`; -> RAM_WAIT.
- IDLE, `req`=1, `addr`>=`IO_BASE`: perform I/O access this cycle (offset = `addr[7:0]`), latch read value; -> RESP.
- RAM_WAIT: if `cnt`=0, latch `ramRdata` (write: latch 0), -> RESP; else `cnt`-1.
- RESP: `ready`=1, `rdata`=latched value; -> IDLE. `req` not sampled in RESP.
- I/O map (offset): 0 OUT (R/W), 1 TIMER (R/W), 2 CMP (R/W), 3 STATUS (R; write-1-to-clear bit0; bits 15:1 read 0). Other offsets: read 0, write ignored.
- TIMER increments by 1 each cycle, wraps 16'hFFFF->0. When TIMER = CMP (pre-increment value), STATUS[0] set.
- Collisions: TIMER write beats increment (written value appears next cycle, no +1). STATUS set beats W1C clear in same cycle.
- `req`/`addr`/`we`/`wdata` sampled only in IDLE; CPU holds them until `ready`. Dropping `req` mid-transaction does not abort; `ready` still pulses.
- Reset (any state): state IDLE, `cnt`=0, `ready`=0, `rdata`=0, `ramEn`=0, OUT=0, TIMER=0, CMP=16'hFFFF, STATUS=0, `irq`=0. In-flight transaction dropped, no `ready`.

## Timing
- I/O latency: `req` accepted cycle N -> `ready` cycle N+1.
- RAM latency: `ramEn` cycle N -> capture cycle N+1+`WAIT_STATES` -> `ready` cycle N+2+`WAIT_STATES` (2 wait states: `ready` at N+4).
- Throughput: next request accepted earliest the cycle after `ready`; back-to-back I/O = 1 access per 2 cycles.
- `ramEn`, `ready` never high two consecutive cycles.
- `outPort` and `irq` registered; `outPort` updates cycle after write accept.

## Structure
- Shared constants include: state encodings, I/O offsets (OUT, TIMER, CMP, STATUS), reset value of CMP.
- One sub-module: `io_timer` (TIMER, CMP, STATUS, match/W1C/collision logic, `irq`); top holds FSM, decode, OUT register, data mux.

## Test plan
- Reset, then read 16'hFF03 -> `ready` one cycle later, `rdata`=0; all outputs at reset values.
- Write 16'h00A5 to 16'h0100 (WAIT_STATES=2) -> `ramEn`=1, `ramWe`=1, `ramAddr`=16'h0100 at N; `ready` at N+4; read back with `ramRdata`=16'h00A5 -> `rdata`=16'h00A5.
- Write 16'h1234 to 16'hFF00 -> `outPort`=16'h1234 next cycle; read 16'hFF00 returns 16'h1234; read 16'hFF10 returns 0.
- Write CMP=5, TIMER=0 -> STATUS[0]/`irq` rise 6 cycles after TIMER write; write 1 to 16'hFF03 -> `irq` low next cycle; clear coinciding with match -> `irq` stays high.
- Assert `rst` during RAM_WAIT -> no `ready`, state IDLE; new I/O request completes normally in 1 cycle.
- `req` held high continuously across two I/O reads -> `ready` at N+1 and N+3, never consecutive.
